// File: rtl/json_stream_arb.sv
// Two-source packet arbiter feeding a JSON parser: round-robin per packet,
// registered output stage, forced truncation at MAX_BEATS with drain of the tail.
module json_stream_arb #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned KEEP_W    = DATA_W / 8,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s0_data,
  input  logic [KEEP_W-1:0] s0_keep,
  input  logic              s0_last,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic [KEEP_W-1:0] s1_keep,
  input  logic              s1_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_src,
  output logic              trunc_err,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  localparam int unsigned BEAT_W = 16;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                g_q, g_d;
  logic                rr_q, rr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [KEEP_W-1:0]   m_keep_q, m_keep_d;
  logic                m_last_q, m_last_d;
  logic                m_valid_q, m_valid_d;
  logic                m_src_q, m_src_d;
  logic                trunc_q, trunc_d;
  logic [CNT_W-1:0]    pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0]    pkt_cnt1_q, pkt_cnt1_d;

  logic [DATA_W-1:0]   sel_data;
  logic [KEEP_W-1:0]   sel_keep;
  logic                sel_last;
  logic                sel_valid;
  logic                sel_ready;
  logic                accept;

  // Granted source view; only the granted source is ever looked at.
  assign sel_data  = g_q ? s1_data  : s0_data;
  assign sel_keep  = g_q ? s1_keep  : s0_keep;
  assign sel_last  = g_q ? s1_last  : s0_last;
  assign sel_valid = g_q ? s1_valid : s0_valid;

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      g_q        <= 1'b0;
      rr_q       <= 1'b1;
      beat_cnt_q <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_src_q    <= 1'b0;
      trunc_q    <= 1'b0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
      m_src_q    <= m_src_d;
      trunc_q    <= trunc_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  // Next-state, output-register load and source handshake.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q & ~m_ready;
    m_src_d    = m_src_q;
    trunc_d    = 1'b0;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    sel_ready  = 1'b0;
    accept     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Contention goes to the source that was not served last.
        if (s0_valid && s1_valid) begin
          g_d     = ~rr_q;
          state_d = ST_PASS;
        end else if (s0_valid) begin
          g_d     = 1'b0;
          state_d = ST_PASS;
        end else if (s1_valid) begin
          g_d     = 1'b1;
          state_d = ST_PASS;
        end
      end

      ST_PASS: begin
        sel_ready = ~m_valid_q | m_ready;
        accept    = sel_valid & sel_ready;
        if (accept) begin
          m_data_d   = sel_data;
          m_keep_d   = sel_keep;
          m_last_d   = sel_last;
          m_src_d    = g_q;
          m_valid_d  = 1'b1;
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (sel_last || (beat_cnt_q == LAST_BEAT)) begin
            beat_cnt_d = '0;
            if (g_q) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
            else     pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
            if (sel_last) begin
              rr_d    = g_q;
              state_d = ST_IDLE;
            end else begin
              // Truncate: close the packet downstream and swallow the tail.
              m_last_d = 1'b1;
              trunc_d  = 1'b1;
              state_d  = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        sel_ready = 1'b1;
        accept    = sel_valid;
        if (accept && sel_last) begin
          rr_d    = g_q;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign s0_ready  = sel_ready & ~g_q;
  assign s1_ready  = sel_ready &  g_q;
  assign m_data    = m_data_q;
  assign m_keep    = m_keep_q;
  assign m_last    = m_last_q;
  assign m_valid   = m_valid_q;
  assign m_src     = m_src_q;
  assign trunc_err = trunc_q;
  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;

endmodule
